// File: rtl/blink_meter_pkg.sv
// Shared types and defaults for the blink period meter and its synchronizer.
// The edge counter width is fixed, so its wrap point is the same in every build.
package blink_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    STUCK = 2'd2
  } meter_state_t;

  localparam int unsigned DEF_CNT_WIDTH   = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_TIMEOUT     = 50000;
  localparam int unsigned EDGE_CNT_WIDTH  = 8;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer chain with a registered any-edge pulse one cycle after the synced level moves.
// Latency: g_STAGES cycles to level, g_STAGES+1 to sig_edge; no backpressure.
module sync_edge_detect #(
  parameter int unsigned g_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic level,
  output logic sig_edge
);

  logic [g_STAGES-1:0] r_sync;
  logic                r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_prev   <= 1'b0;
      sig_edge <= 1'b0;
    end else begin
      r_sync   <= {r_sync[g_STAGES-2:0], sig};
      r_prev   <= r_sync[g_STAGES-1];
      sig_edge <= r_sync[g_STAGES-1] ^ r_prev;
    end
  end

  assign level = r_sync[g_STAGES-1];

endmodule

// File: rtl/blink_period_meter.sv
// Measures the edge-to-edge interval of an async square wave; o_Valid lands g_SYNC_STAGES+1 cycles after an i_Sig change.
// No backpressure: strobes last one cycle. Optional min/max tracking under BLINK_PERIOD_METER_MINMAX_EN.
module blink_period_meter
  import blink_meter_pkg::*;
#(
  parameter int unsigned g_CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned g_SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned g_TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic                      i_Sig,
  input  logic                      i_Clear,
  output logic [g_CNT_WIDTH-1:0]    o_Half_Period,
  output logic                      o_Valid,
  output logic                      o_Level,
  output logic                      o_Stuck,
  output logic [EDGE_CNT_WIDTH-1:0] o_Edge_Count
`ifdef BLINK_PERIOD_METER_MINMAX_EN
  ,
  output logic [g_CNT_WIDTH-1:0]    o_Min_Period,
  output logic [g_CNT_WIDTH-1:0]    o_Max_Period
`endif
);

  localparam logic [g_CNT_WIDTH-1:0]    c_TIMEOUT = g_CNT_WIDTH'(g_TIMEOUT);
  localparam logic [g_CNT_WIDTH-1:0]    c_ONE     = g_CNT_WIDTH'(1);
  localparam logic [EDGE_CNT_WIDTH-1:0] c_EC_ONE  = EDGE_CNT_WIDTH'(1);

  meter_state_t           r_State;
  logic [g_CNT_WIDTH-1:0] r_Cnt;
  logic                   w_Edge;

  sync_edge_detect #(
    .g_STAGES (g_SYNC_STAGES)
  ) u_sync (
    .clk      (i_Clk),
    .rst_n    (i_Rst_L),
    .sig      (i_Sig),
    .level    (o_Level),
    .sig_edge (w_Edge)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State       <= IDLE;
      r_Cnt         <= '0;
      o_Half_Period <= '0;
      o_Valid       <= 1'b0;
      o_Stuck       <= 1'b0;
      o_Edge_Count  <= '0;
`ifdef BLINK_PERIOD_METER_MINMAX_EN
      o_Min_Period  <= '1;
      o_Max_Period  <= '0;
`endif
    end else if (i_Clear) begin
      // A coincident edge is dropped: no count, no state change.
      r_State       <= IDLE;
      r_Cnt         <= '0;
      o_Half_Period <= '0;
      o_Valid       <= 1'b0;
      o_Stuck       <= 1'b0;
      o_Edge_Count  <= '0;
`ifdef BLINK_PERIOD_METER_MINMAX_EN
      o_Min_Period  <= '1;
      o_Max_Period  <= '0;
`endif
    end else begin
      o_Valid <= 1'b0;
      if (w_Edge) begin
        r_Cnt        <= c_ONE;
        o_Edge_Count <= o_Edge_Count + c_EC_ONE;
      end else if (r_Cnt != c_TIMEOUT) begin
        r_Cnt <= r_Cnt + c_ONE;
      end

      case (r_State)
        IDLE: begin
          if (w_Edge) r_State <= ARMED;
        end
        ARMED: begin
          if (w_Edge) begin
            o_Half_Period <= r_Cnt;
            o_Valid       <= 1'b1;
`ifdef BLINK_PERIOD_METER_MINMAX_EN
            if (r_Cnt < o_Min_Period) o_Min_Period <= r_Cnt;
            if (r_Cnt > o_Max_Period) o_Max_Period <= r_Cnt;
`endif
          end else if (r_Cnt == c_TIMEOUT) begin
            r_State <= STUCK;
            o_Stuck <= 1'b1;
          end
        end
        STUCK: begin
          // The interval spanning the stall is meaningless, so it is not reported.
          if (w_Edge) begin
            r_State <= ARMED;
            o_Stuck <= 1'b0;
          end
        end
        default: r_State <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_period_meter.sv
// Directed bench for blink_period_meter with a cycle-level reference model and literal spot checks.
module tb_blink_period_meter;

  localparam int CW = 16;
  localparam int S  = 2;
  localparam int T  = 20;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          sig   = 1'b0;
  logic          clr   = 1'b0;
  logic [CW-1:0] hp;
  logic          vld;
  logic          lvl;
  logic          stk;
  logic [7:0]    ec;
`ifdef BLINK_PERIOD_METER_MINMAX_EN
  logic [CW-1:0] mn;
  logic [CW-1:0] mx;
`endif

  blink_period_meter #(
    .g_CNT_WIDTH   (CW),
    .g_SYNC_STAGES (S),
    .g_TIMEOUT     (T)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Sig         (sig),
    .i_Clear       (clr),
    .o_Half_Period (hp),
    .o_Valid       (vld),
    .o_Level       (lvl),
    .o_Stuck       (stk),
    .o_Edge_Count  (ec)
`ifdef BLINK_PERIOD_METER_MINMAX_EN
    ,
    .o_Min_Period  (mn),
    .o_Max_Period  (mx)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: i_Sig samples per clock; an edge is seen S+1 clocks after it is sampled.
  int  cyc = 0;
  bit  hist [0:7];
  bit  m_edge;
  bit  m_seen, m_stuck, m_vld;
  int  m_last, m_hp, m_ec;
  int  m_min = 65535;
  int  m_max = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int j = 0; j < 8; j++) hist[j] = 1'b0;
      m_seen = 0; m_stuck = 0; m_vld = 0; m_hp = 0; m_ec = 0; m_last = 0;
      m_min = 65535; m_max = 0;
    end else begin
      for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = sig;
      m_edge = (hist[S+1] != hist[S+2]);
      m_vld = 0;
      if (clr) begin
        m_seen = 0; m_stuck = 0; m_hp = 0; m_ec = 0;
        m_min = 65535; m_max = 0;
      end else if (m_edge) begin
        m_ec = (m_ec + 1) % 256;
        if (m_seen && !m_stuck) begin
          m_vld = 1;
          m_hp  = cyc - m_last;
          if (m_hp < m_min) m_min = m_hp;
          if (m_hp > m_max) m_max = m_hp;
        end
        m_stuck = 0;
        m_seen  = 1;
        m_last  = cyc;
      end else if (m_seen && !m_stuck && (cyc - m_last) == T) begin
        m_stuck = 1;
      end
    end
  end

  int vq[$];
  int last_valid_cyc = 0;
  int stuck_rise_cyc = 0;
  bit stk_d = 0;

  always @(negedge clk) begin
    chk("valid", vld, m_vld);
    chk("half_period", hp, m_hp);
    chk("level", lvl, hist[S-1]);
    chk("stuck", stk, m_stuck);
    chk("edge_count", ec, m_ec);
`ifdef BLINK_PERIOD_METER_MINMAX_EN
    chk("min_period", mn, m_min);
    chk("max_period", mx, m_max);
`endif
    if (vld) begin
      vq.push_back(int'(hp));
      last_valid_cyc = cyc;
    end
    if (stk && !stk_d) stuck_rise_cyc = cyc;
    stk_d = stk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle(input int gap);
    sig = ~sig;
    tick(gap);
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  int n;
  bit found;

  initial begin
    // Reset state
    tick(3); #1;
    chk("rst_valid", vld, 0);
    chk("rst_edge_count", ec, 0);
    chk("rst_stuck", stk, 0);
    rst_n = 1'b1;
    tick(2);

    // Steady 5-cycle half period
    vq.delete();
    repeat (6) toggle(5);
    tick(6); #1;
    chk("t1_valid_count", vq.size(), 5);
    foreach (vq[i]) chk("t1_half_period", vq[i], 5);
    chk("t1_edge_count", ec, 6);

    // Stuck detection and recovery
    pulse_clear(); #1;
    chk("t2_clear_edge_count", ec, 0);
    vq.delete();
    repeat (3) toggle(4);
    tick(30); #1;
    chk("t2_valid_count", vq.size(), 2);
    chk("t2_stuck", stk, 1);
    chk("t2_stuck_delay", stuck_rise_cyc - last_valid_cyc, 20);
    chk("t2_hp_retained", hp, 4);
    vq.delete();
    toggle(6); #1;
    chk("t2_recover_no_valid", vq.size(), 0);
    chk("t2_recover_stuck", stk, 0);
    toggle(6); tick(4); #1;
    chk("t2_remeasure_count", vq.size(), 1);
    chk("t2_remeasure", (vq.size() > 0) ? vq[0] : -1, 6);

    // Clear coinciding with a detected edge
    tick(1);
    vq.delete();
    sig = ~sig;
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    #1;
    chk("t3_valid", vld, 0);
    chk("t3_edge_count", ec, 0);
    tick(2);
    toggle(7);
    toggle(7);
    tick(4); #1;
    chk("t3_valid_count", vq.size(), 1);
    chk("t3_half_period", (vq.size() > 0) ? vq[0] : -1, 7);
    chk("t3_edge_count_after", ec, 2);

    // Async reset in the middle of a count
    tick(1);
    toggle(5);
    toggle(2);
    #2;
    rst_n = 1'b0;
    sig   = 1'b0;
    #1;
    chk("t4_async_hp", hp, 0);
    chk("t4_async_valid", vld, 0);
    chk("t4_async_level", lvl, 0);
    chk("t4_async_stuck", stk, 0);
    chk("t4_async_edge_count", ec, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    vq.delete();
    toggle(7); #1;
    chk("t4_first_edge_no_valid", vq.size(), 0);
    sig = ~sig;
    tick(6); #1;
    chk("t4_second_edge_hp", (vq.size() > 0) ? vq[0] : -1, 7);

    // Edge counter wrap, then input-to-strobe latency
    tick(1);
    pulse_clear();
    repeat (260) toggle(2);
    tick(5); #1;
    chk("t5_edge_wrap", ec, 4);
    tick(1);
    sig = ~sig;
    n = 0;
    found = 0;
    while (n < 10 && !found) begin
      @(posedge clk);
      n++;
      #1;
      found = vld;
    end
    chk("t5_latency", n, 4);

`ifdef BLINK_PERIOD_METER_MINMAX_EN
    // Min/max over 5, 3, 9
    tick(2);
    pulse_clear();
    toggle(5);
    toggle(3);
    toggle(9);
    toggle(6); #1;
    chk("t6_min", mn, 3);
    chk("t6_max", mx, 9);
    pulse_clear(); #1;
    chk("t6_min_cleared", mn, 65535);
    chk("t6_max_cleared", mx, 0);
`endif

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_period_meter.md
Name: blink_period_meter

Overview:
- Receive-side counterpart to the LED blinker: measures the half-period of an incoming square wave in clock cycles.
- Typical sources are a blinker output looped back, or an external toggling pin.
- Sits between a raw asynchronous input and status logic or display logic.
- Reports each measured half-period with a one-cycle valid strobe, and flags a stuck (non-toggling) input.

Parameters:
- g_CNT_WIDTH, 16: width of the period counter and of o_Half_Period.
- g_SYNC_STAGES, 2: number of synchronizer flops on i_Sig; legal minimum is 2.
- g_TIMEOUT, 50000: cycle count at which the input is declared stuck; must be less than 2**g_CNT_WIDTH.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Sig  in  1  asynchronous square-wave input to be measured.
- i_Clear  in  1  synchronous clear of measurement state.
- o_Half_Period  out  g_CNT_WIDTH  last measured edge-to-edge interval, in cycles.
- o_Valid  out  1  one-cycle strobe; o_Half_Period updated this cycle.
- o_Level  out  1  synchronized level of i_Sig.
- o_Stuck  out  1  high while no edge has been seen for g_TIMEOUT cycles.
- o_Edge_Count  out  8  number of detected edges; wraps 255 -> 0.

Behaviour:
- Reset (i_Rst_L=0, asynchronous):
  - all synchronizer flops, counter and outputs go to 0;
  - state goes to IDLE.
- Synchronizer and edge detect:
  - i_Sig passes through g_SYNC_STAGES flops.
  - An edge is the XOR of the last sync stage and one further registered copy.
  - Both rising and falling edges count.
  - o_Level is the last sync stage.
- Latency: an i_Sig transition sampled at clock k produces o_Valid at clock k+g_SYNC_STAGES+1.
- Counter r_Cnt:
  - loads 1 on an edge cycle;
  - otherwise increments;
  - saturates at g_TIMEOUT.
  - Edges at detect cycles t and t+N yield o_Half_Period=N.
- States:
  - IDLE: no edge since reset or clear. On edge: load counter, go to ARMED, no o_Valid.
  - ARMED: on edge, register o_Half_Period<=r_Cnt, pulse o_Valid, reload counter. When r_Cnt reaches g_TIMEOUT, go to STUCK and set o_Stuck.
  - STUCK: o_Stuck=1. On edge: clear o_Stuck, reload counter, go to ARMED, no o_Valid (the interval is invalid).
- o_Edge_Count increments on every detected edge in every state, and wraps.
- o_Half_Period holds its value between strobes; it is not cleared on entering STUCK.
- i_Clear:
  - state goes to IDLE; o_Stuck, o_Valid, o_Edge_Count and o_Half_Period go to 0;
  - the synchronizer is untouched.
  - Clear on the same cycle as an edge: clear wins, and the edge is discarded.
- Minimum measurable interval is 1, for back-to-back edges.

Optional Feature:
- Macro: BLINK_PERIOD_METER_MINMAX_EN.
- Defined:
  - adds outputs o_Min_Period and o_Max_Period, each g_CNT_WIDTH wide;
  - both update on the same cycle as o_Valid, using the new sample;
  - reset and i_Clear set min to all-ones and max to 0.
- Undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Package blink_meter_pkg holds:
  - the state enum (IDLE, ARMED, STUCK);
  - default width and timeout constants;
  - the edge-count width constant (8).
- Sub-module sync_edge_detect covers the synchronizer chain and edge/level outputs. It is parameterized by stage count and reused for button inputs.

Test Plan:
- Clock period 2, i_Sig toggles every 10 time units (5 cycles): first edge gives no o_Valid; every later edge gives o_Valid with o_Half_Period=5; o_Edge_Count increments each edge.
- Set g_TIMEOUT=20 and hold i_Sig constant after 3 edges: o_Stuck rises exactly 20 cycles after the last detected edge; o_Half_Period retains its old value. The next edge drops o_Stuck with no o_Valid; the following edge measures correctly.
- Assert i_Clear on the same cycle as a detected edge: no o_Valid; state is IDLE; o_Edge_Count=0. The next two edges, 7 cycles apart, give o_Half_Period=7.
- Pulse i_Rst_L low mid-count: all outputs 0 immediately, asynchronously. After release, the first edge gives no o_Valid.
- Run 260 edges: o_Edge_Count wraps to 4. Also check the g_SYNC_STAGES+1 latency from an i_Sig change to o_Valid.
- With MINMAX_EN, half-periods 5, 3, 9: o_Min_Period=3, o_Max_Period=9. After i_Clear they read all-ones and 0 respectively.
